// File: rtl/uart_rx_os_if.sv
// Bus-side hold-register handshake of the oversampling UART receiver.
// The receiver drives the word and status flags; the consumer returns rd_ack.
interface uart_rx_os_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              u_rx_done;
    logic              rx_valid;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;
    logic              rd_ack;

    modport master (
        output data, u_rx_done, rx_valid, frame_err, parity_err, overrun,
        input  rd_ack
    );

    modport slave (
        input  data, u_rx_done, rx_valid, frame_err, parity_err, overrun,
        output rd_ack
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, false-start rejection, framing/overrun
// detection and a valid/ack hold register. Optional parity bit enabled by UART_RX_PARITY_EN.
module uart_rx_os #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_rx,
    input  logic          u_rx,
    uart_rx_os_if.master  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Received parity bit disagrees with the XOR of the data bits and the configured sense.
    function automatic logic parity_bad(input logic [DATA_W-1:0] d, input logic p);
        return p ^ (^d) ^ 1'(PARITY_ODD);
    endfunction
`endif

    logic [1:0]        sync_r;
    logic              rx_s;
    logic              rx_prev_r;
    state_t            state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [IDX_W-1:0]  idx_r, idx_next_s;
    logic [DATA_W-1:0] shift_r, shift_next_s;
    logic              ferr_r, ferr_next_s;
    logic              perr_r, perr_next_s;
    logic              done_s;

    logic [DATA_W-1:0] data_r;
    logic              done_r;
    logic              valid_r;
    logic              frame_err_r;
    logic              parity_err_r;
    logic              overrun_r;

    assign rx_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], u_rx};
            rx_prev_r <= rx_s;
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            ferr_r  <= 1'b0;
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            shift_r <= shift_next_s;
            ferr_r  <= ferr_next_s;
            perr_r  <= perr_next_s;
        end
    end

    // Next-state logic; every sample point falls on the middle of a bit period.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + CNT_W'(1);
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        ferr_next_s  = ferr_r;
        perr_next_s  = perr_r;
        done_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_next_s  = '0;
                idx_next_s  = '0;
                ferr_next_s = 1'b0;
                perr_next_s = 1'b0;
                if (en_rx && rx_prev_r && !rx_s) begin
                    state_next_s = S_START;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_r == CNT_MID) begin
                    cnt_next_s   = '0;
                    state_next_s = rx_s ? S_IDLE : S_DATA;
                end else begin
                    state_next_s = S_START;
                end
            end
            S_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = '0;
                    shift_next_s = {rx_s, shift_r[DATA_W-1:1]};
                    if (idx_r == IDX_LAST) begin
                        idx_next_s = '0;
`ifdef UART_RX_PARITY_EN
                        state_next_s = S_PARITY;
`else
                        state_next_s = S_STOP;
`endif
                    end else begin
                        idx_next_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_next_s = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = '0;
                    perr_next_s  = parity_bad(shift_r, rx_s);
                    state_next_s = S_STOP;
                end else begin
                    state_next_s = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s  = '0;
                    ferr_next_s = ferr_r | ~rx_s;
                    if (idx_r == STOP_LAST) begin
                        // Leaving at mid-stop lets a start edge right after the stop bit be caught.
                        done_s       = 1'b1;
                        state_next_s = S_IDLE;
                    end else begin
                        idx_next_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_next_s = S_STOP;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Hold register toward the bus; an ack coinciding with completion keeps the new word valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r       <= '0;
            done_r       <= 1'b0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            done_r <= done_s;
            if (done_s) begin
                data_r       <= shift_r;
                frame_err_r  <= ferr_next_s;
                parity_err_r <= perr_r;
                valid_r      <= 1'b1;
                if (valid_r && !bus.rd_ack) begin
                    overrun_r <= 1'b1;
                end else if (bus.rd_ack) begin
                    overrun_r <= 1'b0;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else if (bus.rd_ack) begin
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
            end else begin
                valid_r   <= valid_r;
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.data       = data_r;
    assign bus.u_rx_done  = done_r;
    assign bus.rx_valid   = valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.parity_err = parity_err_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os (8 data bits, 16 clocks/bit, 1 stop bit); the stimulus
// pushes hand-computed frame results and a negedge monitor checks each u_rx_done.
module tb_uart_rx_os;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int DONE_LAT = 155 + 16;
`else
    localparam int DONE_LAT = 155;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       ovr;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en_rx = 1'b1;
    logic u_rx  = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    uart_rx_os_if #(.DATA_W(8)) bus ();

    uart_rx_os #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en_rx (en_rx),
        .u_rx  (u_rx),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed frame is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.u_rx_done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got data 0x%0h at cycle %0d, expected no frame", bus.data, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("data",       {24'd0, bus.data},  {24'd0, mon_e.data});
                check("frame_err",  {31'd0, bus.frame_err},  {31'd0, mon_e.ferr});
                check("parity_err", {31'd0, bus.parity_err}, {31'd0, mon_e.perr});
                check("overrun",    {31'd0, bus.overrun},    {31'd0, mon_e.ovr});
                check("rx_valid",   {31'd0, bus.rx_valid},   32'd1);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_val,
                              input logic push, input logic ferr, input logic perr, input logic ovr);
        logic par_bit;
        par_bit = (^d) ^ par_flip;
        @(negedge clk);
        u_rx = 1'b0;
        if (push) sb_q.push_back('{d, ferr, perr, ovr, cyc + DONE_LAT});
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        u_rx = par_bit;
        repeat (CPB) @(negedge clk);
`endif
        u_rx = stop_val;
        repeat (CPB) @(negedge clk);
        u_rx = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d frames outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"},  {24'd0, bus.data}, 32'd0);
        check({name, "_flags"}, {26'd0, bus.u_rx_done, bus.rx_valid, bus.frame_err,
                                 bus.parity_err, bus.overrun, 1'b0}, 32'd0);
    endtask

    initial begin
        bus.rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean 8N1 frame, exact latency, then ack clears rx_valid.
        send_frame(8'h19, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain("frame_19");
        ack();
        check("ack_clears_valid", {31'd0, bus.rx_valid}, 32'd0);
        ack();
        check("ack_idle_no_effect", {31'd0, bus.rx_valid}, 32'd0);

        // Four-cycle low glitch is rejected; the next frame still decodes.
        @(negedge clk);
        u_rx = 1'b0;
        repeat (4) @(negedge clk);
        u_rx = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain("frame_a5");
        ack();

        // Low stop bit: word delivered with frame_err, next clean frame clears it.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain("frame_3c_ferr");
        ack();
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain("frame_81");
        ack();

        // Back-to-back frames without ack produce overrun.
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain("frame_11_22");
        check("overrun_data", {24'd0, bus.data}, 32'h22);
        ack();
        check("ack_clears_overrun", {30'd0, bus.overrun, bus.rx_valid}, 32'd0);

        // Ack on the completion cycle: word stays valid, no overrun.
        send_frame(8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (DONE_LAT - 1) @(negedge clk);
                bus.rd_ack = 1'b1;
                @(negedge clk);
                bus.rd_ack = 1'b0;
            end
        join
        wait_drain("frame_99_ack");
        check("ack_at_done_valid", {31'd0, bus.rx_valid}, 32'd1);
        ack();

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1.
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_drain("parity_bad");
        ack();
        send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain("parity_good");
        ack();
`endif

        // en_rx dropped mid-frame: frame completes, the following start is ignored.
        fork
            send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                repeat (50) @(negedge clk);
                en_rx = 1'b0;
            end
        join
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain("frame_c3_disable");
        check("disabled_data_kept", {24'd0, bus.data}, 32'hC3);
        en_rx = 1'b1;

        // Reset during data bits clears every output at once; the next frame decodes.
        fork
            send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_all_zero("midframe_reset");
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain("frame_5a");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
